// File: rtl/eth_frame_matcher_pkg.sv
// Shared definitions for the multi-pattern Ethernet frame matcher.
// Pattern word layout, FSM states and small helpers.
package eth_frame_matcher_pkg;
  localparam int PAT_W    = 10;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 7;
  localparam int CMP_BIT  = 8;
  localparam int END_BIT  = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVFL
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/eth_frame_matcher_multi_if.sv
// RX byte stream bundle feeding the frame matcher.
// No tready: every valid beat is consumed.
interface eth_frame_matcher_multi_if;
  logic [7:0] tdata;
  logic       tuser;
  logic       tlast;
  logic       tvalid;

  modport master (
    output tdata, tuser, tlast, tvalid
  );
  modport slave (
    input tdata, tuser, tlast, tvalid
  );
endinterface

// File: rtl/eth_frame_matcher_lane.sv
// One pattern lane: alive/done tracking and per-byte compare.
// hit is the post-compare result used for the frame report.
module eth_frame_matcher_lane
  import eth_frame_matcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_vld,
  input  logic [7:0]       byte_in,
  input  logic [PAT_W-1:0] word,
  output logic             hit
);
  logic alive_q, alive_d;
  logic done_q, done_d;
  logic cmp_alive, cmp_done;

  always_comb begin
    cmp_alive = alive_q;
    cmp_done  = done_q;
    if (cmp_vld && !done_q) begin
      if (word[CMP_BIT] &&
          byte_in != word[DATA_MSB:DATA_LSB])
        cmp_alive = 1'b0;
      if (word[END_BIT])
        cmp_done = 1'b1;
    end
    hit = cmp_alive & cmp_done;
    // a new frame overrides the old frame's last compare
    alive_d = start ? 1'b1 : cmp_alive;
    done_d  = start ? 1'b0 : cmp_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      alive_q <= alive_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: rtl/eth_frame_matcher_multi.sv
// Matches each RX frame against NUM_PATTERNS masked patterns.
// Reports one result vector, length and error per frame.
module eth_frame_matcher_multi
  import eth_frame_matcher_pkg::*;
#(
  parameter  int NUM_PATTERNS = 3,
  parameter  int MEM_DEPTH    = 2048,
  localparam int AW           = $clog2(MEM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  eth_frame_matcher_multi_if.slave      s_axis,
  input  logic [NUM_PATTERNS-1:0]       match_en,
  input  logic [NUM_PATTERNS-1:0]       match_mode,
  output logic [AW-1:0]                 mem_addr,
  input  logic [PAT_W*NUM_PATTERNS-1:0] mem_rdata,
  output logic                          match_valid,
  output logic [NUM_PATTERNS-1:0]       match,
  output logic [15:0]                   match_frame_len,
  output logic                          match_frame_err
);
  localparam int NP = NUM_PATTERNS;

  state_t          state_q, state_d;
  logic [AW-1:0]   offset_q, offset_d;
  logic [NP-1:0]   en_q, en_d, mode_q, mode_d;
  logic [15:0]     len_q, len_d, flen_q, flen_d;
  logic [7:0]      byte_q, byte_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic            last_q, last_d;
  logic            tuser_q, tuser_d;
  logic            mv_q, mv_d;
  logic [NP-1:0]   match_q, match_d;
  logic [15:0]     mlen_q, mlen_d;
  logic            merr_q, merr_d;
  logic [NP-1:0]   hit;
  logic            beat, start, at_end;
  logic [15:0]     len_inc;

  assign beat    = s_axis.tvalid;
  assign start   = beat && (state_q == IDLE);
  assign at_end  = offset_q == AW'(MEM_DEPTH - 1);
  assign len_inc = sat_inc(len_q);

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    en_d      = en_q;
    mode_d    = mode_q;
    len_d     = len_q;
    flen_d    = flen_q;
    byte_d    = byte_q;
    cmp_vld_d = 1'b0;
    last_d    = 1'b0;
    tuser_d   = tuser_q;
    mv_d      = last_q;
    match_d   = match_q;
    mlen_d    = mlen_q;
    merr_d    = merr_q;
    if (beat) begin
      byte_d    = s_axis.tdata;
      cmp_vld_d = state_q != OVFL;
      last_d    = s_axis.tlast;
      len_d     = len_inc;
      if (start) begin
        en_d   = match_en;
        mode_d = match_mode;
      end
      if (s_axis.tlast) begin
        state_d  = IDLE;
        offset_d = '0;
        len_d    = '0;
        flen_d   = len_inc;
        tuser_d  = s_axis.tuser;
      end else if (state_q != OVFL) begin
        // past the last memory byte nothing more is compared
        if (at_end) begin
          state_d = OVFL;
        end else begin
          state_d  = RUN;
          offset_d = offset_q + AW'(1);
        end
      end
    end
    if (last_q) begin
      match_d = en_q & hit & ~(mode_q & {NP{tuser_q}});
      mlen_d  = flen_q;
      merr_d  = tuser_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      flen_q    <= '0;
      byte_q    <= '0;
      cmp_vld_q <= 1'b0;
      last_q    <= 1'b0;
      tuser_q   <= 1'b0;
      mv_q      <= 1'b0;
      match_q   <= '0;
      mlen_q    <= '0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      flen_q    <= flen_d;
      byte_q    <= byte_d;
      cmp_vld_q <= cmp_vld_d;
      last_q    <= last_d;
      tuser_q   <= tuser_d;
      mv_q      <= mv_d;
      match_q   <= match_d;
      mlen_q    <= mlen_d;
      merr_q    <= merr_d;
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_lane
    eth_frame_matcher_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cmp_vld (cmp_vld_q),
      .byte_in (byte_q),
      .word    (mem_rdata[PAT_W*i +: PAT_W]),
      .hit     (hit[i])
    );
  end

  assign mem_addr        = offset_q;
  assign match_valid     = mv_q;
  assign match           = match_q;
  assign match_frame_len = mlen_q;
  assign match_frame_err = merr_q;
endmodule

// File: tb/tb_eth_frame_matcher_multi.sv
// Bench for eth_frame_matcher_multi: directed and random frames
// checked against a frame-level reference model.
module tb_eth_frame_matcher_multi;
  localparam int NP = 3;
  localparam int MD = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    match_en, match_mode;
  logic [AW-1:0]    mem_addr;
  logic [10*NP-1:0] mem_rdata;
  logic             match_valid;
  logic [NP-1:0]    match;
  logic [15:0]      match_frame_len;
  logic             match_frame_err;

  eth_frame_matcher_multi_if s_axis ();

  eth_frame_matcher_multi #(
    .NUM_PATTERNS (NP),
    .MEM_DEPTH    (MD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (s_axis),
    .match_en        (match_en),
    .match_mode      (match_mode),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .match_valid     (match_valid),
    .match           (match),
    .match_frame_len (match_frame_len),
    .match_frame_err (match_frame_err)
  );

  always #5 clk = ~clk;

  logic [9:0] pmem [NP][MD];
  logic [7:0] fb [128];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    mem_rdata <= {pmem[2][mem_addr], pmem[1][mem_addr],
                  pmem[0][mem_addr]};

  typedef struct {
    logic [NP-1:0] m;
    logic [15:0]   len;
    logic          err;
    int            cyc;
  } rpt_t;

  rpt_t exp_q[$];
  rpt_t act_q[$];

  always @(negedge clk)
    if (match_valid === 1'b1)
      act_q.push_back('{match, match_frame_len,
                        match_frame_err, cyc});

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // first END flag closes the pattern; frame must reach it
  function automatic logic [NP-1:0] model(
    input int base, input int n, input bit err,
    input logic [NP-1:0] en, input logic [NP-1:0] mode);
    logic [NP-1:0] r;
    int e;
    bit ok;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      e = -1;
      for (int a = MD - 1; a >= 0; a--)
        if (pmem[p][a][9]) e = a;
      ok = (e >= 0) && (n > e);
      for (int a = 0; a <= e; a++)
        if (pmem[p][a][8] && fb[base+a] !== pmem[p][a][7:0])
          ok = 1'b0;
      r[p] = ok && en[p] && !(mode[p] && err);
    end
    return r;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
    end
  endtask

  task automatic drive_frame(input int n, input bit err,
                             input bit gaps, input int tog_at,
                             input logic [NP-1:0] tog_en);
    logic [NP-1:0] en_s, mode_s;
    int lc;
    en_s = '0;
    mode_s = '0;
    lc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_axis.tvalid = 1'b0;
      end
      @(negedge clk);
      if (i == 0) begin
        en_s = match_en;
        mode_s = match_mode;
      end
      if (i == tog_at) match_en = tog_en;
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = fb[i];
      s_axis.tlast  = (i == n - 1);
      s_axis.tuser  = (i == n - 1) ? err : 1'($urandom);
      lc = cyc;
    end
    exp_q.push_back('{model(0, n, err, en_s, mode_s),
                      16'(n), err, lc + 2});
  endtask

  task automatic check_reports();
    rpt_t e, a;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (act_q.size() == 0 && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("rpt_present", 32'(act_q.size() > 0), 32'd1);
      if (act_q.size() > 0) begin
        a = act_q.pop_front();
        check("match", 32'(a.m), 32'(e.m));
        check("len", 32'(a.len), 32'(e.len));
        check("err", 32'(a.err), 32'(e.err));
        check("latency", 32'(a.cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic rand_fill();
    for (int a = 0; a < 128; a++) fb[a] = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tdata  = '0;
    match_en   = '0;
    match_mode = '0;
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < MD; a++) pmem[p][a] = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(match_valid), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_len", 32'(match_frame_len), 32'd0);
    check("rst_err", 32'(match_frame_err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // pattern 0: 01 02 03, END at 2
    pmem[0][0] = 10'h101;
    pmem[0][1] = 10'h102;
    pmem[0][2] = 10'h303;
    rand_fill();
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    match_en = 3'b001;
    drive_frame(60, 1'b0, 1'b0, -1, '0);
    idle(4);
    check_reports();
    check("addr_idle", 32'(mem_addr), 32'd0);

    // don't-care byte 1
    pmem[0][1] = 10'h002;
    fb[1] = 8'hFF;
    drive_frame(8, 1'b0, 1'b0, -1, '0);
    idle(2);
    fb[1] = 8'h02; fb[2] = 8'h04;
    drive_frame(8, 1'b0, 1'b0, -1, '0);
    idle(4);
    check_reports();

    // pattern 1 with error-free requirement
    pmem[1][0] = 10'h1AA;
    pmem[1][1] = 10'h1BB;
    pmem[1][2] = 10'h1CC;
    pmem[1][3] = 10'h3DD;
    rand_fill();
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;
    match_en = 3'b011;
    match_mode = 3'b010;
    drive_frame(12, 1'b1, 1'b0, -1, '0);
    idle(2);
    match_mode = 3'b000;
    drive_frame(12, 1'b1, 1'b1, -1, '0);
    idle(4);
    check_reports();

    // END at last memory byte, overflow, pattern without END
    for (int a = 0; a < MD; a++) begin
      pmem[1][a] = '0;
      pmem[2][a] = {(a == MD - 1), 1'b1, 8'(a * 7 + 5)};
    end
    rand_fill();
    for (int a = 0; a < MD; a++) fb[a] = pmem[2][a][7:0];
    match_en = 3'b111;
    drive_frame(40, 1'b0, 1'b1, -1, '0);
    idle(2);
    drive_frame(15, 1'b0, 1'b0, -1, '0);
    idle(2);
    fb[9] = fb[9] ^ 8'h40;
    drive_frame(40, 1'b0, 1'b0, -1, '0);
    idle(4);
    check_reports();
    check("addr_ovfl_idle", 32'(mem_addr), 32'd0);

    // back-to-back, enables toggled mid-frame
    rand_fill();
    for (int a = 0; a < MD; a++) fb[a] = pmem[2][a][7:0];
    match_en = 3'b101;
    drive_frame(64, 1'b0, 1'b0, 30, 3'b011);
    rand_fill();
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    drive_frame(64, 1'b0, 1'b0, -1, '0);
    idle(4);
    check_reports();

    // random patterns and frames
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        int endp;
        endp = $urandom_range(0, MD);
        for (int a = 0; a < MD; a++)
          pmem[p][a] = {(a == endp), ($urandom_range(0, 3) != 0),
                        8'($urandom)};
      end
      for (int f = 0; f < 15; f++) begin
        int p;
        p = $urandom_range(0, NP - 1);
        rand_fill();
        if ($urandom_range(0, 1) == 1)
          for (int a = 0; a < MD; a++) fb[a] = pmem[p][a][7:0];
        if ($urandom_range(0, 3) == 0) begin
          int k;
          k = $urandom_range(0, MD - 1);
          fb[k] = fb[k] ^ 8'h10;
        end
        match_en = 3'($urandom);
        match_mode = 3'($urandom);
        drive_frame($urandom_range(1, 40), 1'($urandom),
                    1'($urandom), -1, '0);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(4);
      check_reports();
    end

    // reset at byte 20; bytes 21.. form a new frame
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < MD; a++) pmem[p][a] = '0;
    pmem[0][0] = 10'h101;
    pmem[0][1] = 10'h102;
    pmem[0][2] = 10'h303;
    rand_fill();
    fb[21] = 8'h01; fb[22] = 8'h02; fb[23] = 8'h03;
    match_en = 3'b001;
    match_mode = 3'b000;
    begin
      int lc;
      lc = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (i == 21) begin
          check("rrst_valid", 32'(match_valid), 32'd0);
          check("rrst_match", 32'(match), 32'd0);
          check("rrst_len", 32'(match_frame_len), 32'd0);
          check("rrst_err", 32'(match_frame_err), 32'd0);
          check("rrst_addr", 32'(mem_addr), 32'd0);
        end
        rst_n = (i != 20);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = fb[i];
        s_axis.tlast  = (i == 29);
        s_axis.tuser  = 1'b0;
        lc = cyc;
      end
      exp_q.push_back('{model(21, 9, 1'b0, 3'b001, 3'b000),
                        16'd9, 1'b0, lc + 2});
    end
    idle(4);
    check_reports();
    check("no_extra", 32'(act_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
